// File: rtl/sd_pkg.sv
// sd_pkg: shared types and helpers for the sd101 serial frame transmitter.
// Holds the FSM state encoding, the default 101 sync marker and the
// counter-width helper used to size the bit counter.
package sd_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_SYNC = 2'b01,
      S_DATA = 2'b10,
      S_GAP  = 2'b11
   } state_t;
   localparam logic [2:0] SYNC_101 = 3'b101;
   // Bits needed to count down from max(a,b)-1, never fewer than one.
   function automatic int CNT_W(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction
endpackage

// File: rtl/sd_piso_shift.sv
// sd_piso_shift: parallel-in/serial-out shift register, MSB first.
// Ports: clk, rst_n (async active-low, clears to 0), load (capture d),
// shift (shift left by one), d (parallel word), msb (current top bit).
module sd_piso_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         msb
);
   logic [W-1:0] q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (load) q <= d;
      else if (shift) q <= q << 1;
   assign msb = q[W-1];
endmodule

// File: rtl/sd101_frame_tx.sv
// sd101_frame_tx: serial frame transmitter (sync marker, payload MSB-first, guard 0).
// Ports: clk, rst_n (async active-low), din/din_valid/din_ready (payload
// handshake, accepted only in IDLE), dout (serial line, 0 when idle),
// dout_en (high for sync and payload bits), busy (not IDLE), done (guard-bit pulse).
module sd101_frame_tx
   import sd_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                SYNC_W = 3,
   parameter logic [SYNC_W-1:0] SYNC   = SYNC_W'(SYNC_101)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              dout,
   output logic              dout_en,
   output logic              busy,
   output logic              done
);
   localparam int CW = CNT_W(SYNC_W, DATA_W);
   state_t            state, nxt;
   logic [CW-1:0]     cnt;
   logic [SYNC_W-1:0] sync_sh;
   logic              xfer, msb, last;
   assign xfer    = din_valid && din_ready;
   assign last    = cnt == '0;
   // Select the current marker bit by shifting, so the index width never matters.
   assign sync_sh = SYNC >> cnt;
   sd_piso_shift #(.W(DATA_W)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (xfer),
      .shift (state == S_DATA),
      .d     (din),
      .msb   (msb)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= nxt;
   always_comb begin
      nxt = S_IDLE;
      case (state)
         S_IDLE:  nxt = xfer ? S_SYNC : S_IDLE;
         S_SYNC:  nxt = last ? S_DATA : S_SYNC;
         S_DATA:  nxt = last ? S_GAP : S_DATA;
         default: nxt = S_IDLE;
      endcase
   end
   // Counter is reloaded at each phase change instead of wrapping.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else
         case (state)
            S_IDLE:  cnt <= xfer ? CW'(SYNC_W - 1) : '0;
            S_SYNC:  cnt <= last ? CW'(DATA_W - 1) : cnt - 1'b1;
            S_DATA:  cnt <= last ? '0 : cnt - 1'b1;
            default: cnt <= '0;
         endcase
   always_comb begin
      din_ready = state == S_IDLE;
      busy      = state != S_IDLE;
      done      = state == S_GAP;
      dout_en   = (state == S_SYNC) || (state == S_DATA);
      dout      = (state == S_SYNC) ? sync_sh[0] : (state == S_DATA) ? msb : 1'b0;
   end
endmodule
